// File: rtl/lc3b_types.sv
// LC-3b opcode constants, data-memory FSM state type and opcode classifiers.
package lc3b_types;

    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_STB  = 4'h3;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_STI  = 4'hB;
    localparam logic [3:0] OP_TRAP = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } dmem_state_t;

    function automatic logic is_dmem_op(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_STR) || (op == OP_LDB) || (op == OP_STB) ||
               (op == OP_LDI) || (op == OP_STI) || (op == OP_TRAP);
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
    endfunction

    function automatic logic is_byte_op(input logic [3:0] op);
        return (op == OP_LDB) || (op == OP_STB);
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LDR) || (op == OP_LDB) || (op == OP_LDI) || (op == OP_TRAP);
    endfunction

endpackage

// File: rtl/line_word_sel.sv
// Picks the addressed 16-bit word (or sign-extended byte) out of a cache line.
// Purely combinational; no latency, no flow control.
module line_word_sel #(
    parameter int LINE_WORDS = 8
) (
    input  logic [16*LINE_WORDS-1:0]      i_line,
    input  logic [$clog2(LINE_WORDS):0]   i_baddr,
    input  logic                          i_byte_mode,
    output logic [15:0]                   o_value
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic [IDX_W-1:0] w_idx;
    logic [15:0]      w_word;
    logic [7:0]       w_byte;

    assign w_idx   = i_baddr[IDX_W:1];
    assign w_word  = i_line[16*w_idx +: 16];
    assign w_byte  = i_baddr[0] ? w_word[15:8] : w_word[7:0];
    assign o_value = i_byte_mode ? {{8{w_byte[7]}}, w_byte} : w_word;

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-port FSM: runs one LC-3b load/store/TRAP (LDI/STI via a pointer read) per request.
// Min 3 cycles accept->done, +1 per bus wait, +pointer phase; stalls pipeline until done. Option: DMEM_MISALIGN_CHK_EN.
module dmem_access_unit
    import lc3b_types::*;
#(
    parameter  int LINE_WORDS = 8,
    parameter  int ADDR_W     = 16,
    localparam int LINE_BITS  = 16*LINE_WORDS,
    localparam int LINE_BYTES = 2*LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [3:0]            opcode,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [15:0]           wdata,
    input  logic [LINE_BITS-1:0]  dmem_rdata,
    input  logic                  dmem_resp,
    output logic [ADDR_W-1:0]     dmem_address,
    output logic [LINE_BITS-1:0]  dmem_wdata,
    output logic                  dmem_cyc,
    output logic                  dmem_stb,
    output logic                  dmem_write,
    output logic [LINE_BYTES-1:0] dmem_byte_enable,
    output logic [15:0]           rdata_out,
    output logic                  done,
    output logic                  stall
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic                  misalign_err
`endif
);
    localparam int BO_W = $clog2(LINE_BYTES);

    dmem_state_t           r_state;
    logic [3:0]            r_op;
    logic [BO_W-1:0]       r_boff;
    logic [15:0]           r_wdata;
    logic                  r_mis;
    logic                  r_cyc;
    logic                  r_write;
    logic                  r_done;
    logic [ADDR_W-1:0]     r_bus_addr;
    logic [LINE_BITS-1:0]  r_bus_wdata;
    logic [LINE_BYTES-1:0] r_be;
    logic [15:0]           r_rdata;

    logic                  w_req;
    logic [15:0]           w_sel;
    logic [3:0]            w_l_op;
    logic [ADDR_W-1:0]     w_l_addr;
    logic [15:0]           w_l_wd;
    logic                  w_l_ptr;
    logic                  w_l_write;
    logic                  w_l_byte;
    logic                  w_l_go;
    logic [ADDR_W-1:0]     w_l_bus_addr;
    logic [LINE_BYTES-1:0] w_l_be;
    logic [LINE_BITS-1:0]  w_l_wdata;

    assign w_req = req_valid && is_dmem_op(opcode);
    assign stall = w_req && !r_done;

    // Pointer phase reuses the word extractor; only LDB ever selects byte mode.
    line_word_sel #(.LINE_WORDS(LINE_WORDS)) u_sel (
        .i_line      (dmem_rdata),
        .i_baddr     (r_boff),
        .i_byte_mode (r_op == OP_LDB),
        .o_value     (w_sel)
    );

    // Bus setup for the next phase: from the new request in IDLE, from the fetched pointer in PTR.
    always_comb begin
        w_l_op   = opcode;
        w_l_addr = addr;
        w_l_wd   = wdata;
        w_l_ptr  = is_indirect(opcode);
        if (r_state == PTR) begin
            w_l_op   = r_op;
            w_l_addr = ADDR_W'(w_sel);
            w_l_wd   = r_wdata;
            w_l_ptr  = 1'b0;
        end
        w_l_write    = !w_l_ptr && is_store(w_l_op);
        w_l_byte     = !w_l_ptr && is_byte_op(w_l_op);
        w_l_bus_addr = w_l_byte ? w_l_addr : {w_l_addr[ADDR_W-1:1], 1'b0};
        w_l_be       = '1;
        if (w_l_write) begin
            w_l_be = w_l_byte ? (LINE_BYTES'(1) << w_l_addr[BO_W-1:0])
                              : (LINE_BYTES'(3) << {w_l_addr[BO_W-1:1], 1'b0});
        end
        w_l_wdata = (w_l_op == OP_STB) ? {LINE_BYTES{w_l_wd[7:0]}} : {LINE_WORDS{w_l_wd}};
`ifdef DMEM_MISALIGN_CHK_EN
        w_l_go = w_l_byte || !w_l_addr[0];
`else
        w_l_go = 1'b1;
`endif
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic r_misalign_err;
    assign misalign_err = r_misalign_err;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_op        <= '0;
            r_boff      <= '0;
            r_wdata     <= '0;
            r_mis       <= 1'b0;
            r_cyc       <= 1'b0;
            r_write     <= 1'b0;
            r_done      <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_be        <= '0;
            r_rdata     <= '0;
`ifdef DMEM_MISALIGN_CHK_EN
            r_misalign_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_req) begin
                    r_op        <= opcode;
                    r_boff      <= addr[BO_W-1:0];
                    r_wdata     <= wdata;
                    r_state     <= (w_l_ptr && w_l_go) ? PTR : ACCESS;
                    r_cyc       <= w_l_go;
                    r_write     <= w_l_go && w_l_write;
                    r_be        <= w_l_go ? w_l_be : '0;
                    r_bus_addr  <= w_l_bus_addr;
                    r_bus_wdata <= w_l_wdata;
                    r_mis       <= !w_l_go;
                end
                PTR: if (dmem_resp) begin
                    r_boff      <= w_l_addr[BO_W-1:0];
                    r_state     <= ACCESS;
                    r_cyc       <= w_l_go;
                    r_write     <= w_l_go && w_l_write;
                    r_be        <= w_l_go ? w_l_be : '0;
                    r_bus_addr  <= w_l_bus_addr;
                    r_bus_wdata <= w_l_wdata;
                    r_mis       <= !w_l_go;
                end
                ACCESS: if (r_mis || dmem_resp) begin
                    r_cyc   <= 1'b0;
                    r_write <= 1'b0;
                    r_be    <= '0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                    if (!r_mis && is_load(r_op)) r_rdata <= w_sel;
`ifdef DMEM_MISALIGN_CHK_EN
                    r_misalign_err <= r_mis;
`endif
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_mis   <= 1'b0;
                    r_state <= IDLE;
`ifdef DMEM_MISALIGN_CHK_EN
                    r_misalign_err <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dmem_address     = r_bus_addr;
    assign dmem_wdata       = r_bus_wdata;
    assign dmem_cyc         = r_cyc;
    assign dmem_stb         = r_cyc;
    assign dmem_write       = r_write;
    assign dmem_byte_enable = r_be;
    assign rdata_out        = r_rdata;
    assign done             = r_done;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed plus randomized transactions against a line-memory reference model.
module tb_dmem_access_unit;

    localparam logic [3:0] T_ADD = 4'h1, T_LDB = 4'h2, T_STB = 4'h3, T_LDR = 4'h6,
                           T_STR = 4'h7, T_LDI = 4'hA, T_STI = 4'hB, T_TRAP = 4'hF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [3:0]   opcode = '0;
    logic [15:0]  addr = '0;
    logic [15:0]  wdata = '0;
    logic [127:0] dmem_rdata = '0;
    logic         dmem_resp = 1'b0;
    logic [15:0]  dmem_address;
    logic [127:0] dmem_wdata;
    logic         dmem_cyc, dmem_stb, dmem_write, done, stall;
    logic [15:0]  dmem_byte_enable;
    logic [15:0]  rdata_out;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [15:0]  exp_rdata = '0;

    dmem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .opcode(opcode), .addr(addr),
        .wdata(wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_cyc(dmem_cyc),
        .dmem_stb(dmem_stb), .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
        .rdata_out(rdata_out), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: memory line viewed as a flat array of bytes / words.
    function automatic logic [15:0] m_word(input logic [127:0] line, input logic [15:0] a);
        return 16'(line >> (16 * ((a >> 1) % 8)));
    endfunction

    function automatic logic [15:0] m_byte(input logic [127:0] line, input logic [15:0] a);
        logic [7:0] b;
        b = 8'(line >> (8 * (a % 16)));
        return 16'($signed(b));
    endfunction

    function automatic logic m_store(input logic [3:0] op);
        return op == T_STR || op == T_STB || op == T_STI;
    endfunction

    function automatic logic m_load(input logic [3:0] op);
        return op == T_LDR || op == T_LDB || op == T_LDI || op == T_TRAP;
    endfunction

    function automatic logic [15:0] m_be(input logic [3:0] op, input logic [15:0] a);
        if (op == T_STB) return 16'(1) << (a % 16);
        return 16'h3 << (2 * ((a >> 1) % 8));
    endfunction

    task automatic bus_phase(input string tag, input logic [3:0] op, input logic ptr,
                             input logic [15:0] a, input logic [15:0] wd,
                             input logic [127:0] line, input int waits);
        logic wr, byt;
        wr  = !ptr && m_store(op);
        byt = !ptr && (op == T_LDB || op == T_STB);
        for (int i = 0; i <= waits; i++) begin
            tick();
            chk({tag, ".cyc"}, dmem_cyc, 1'b1);
            chk({tag, ".stb"}, dmem_stb, 1'b1);
            chk({tag, ".stall"}, stall, 1'b1);
            chk({tag, ".done"}, done, 1'b0);
            chk({tag, ".addr"}, dmem_address, byt ? a : (a & 16'hFFFE));
            chk({tag, ".write"}, dmem_write, wr);
            chk({tag, ".be"}, dmem_byte_enable, wr ? m_be(op, a) : 16'hFFFF);
            if (wr)
                chk({tag, ".wdata"}, dmem_wdata,
                    (op == T_STB) ? {16{wd[7:0]}} : {8{wd}});
            dmem_rdata = line;
            dmem_resp  = (i == waits);
        end
    endtask

    task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] wd,
                           input logic [127:0] pline, input logic [127:0] line,
                           input int wp, input int wa);
        logic [15:0] ea;
        req_valid = 1'b1; opcode = op; addr = a; wdata = wd;
        #1;
        chk("req.stall", stall, 1'b1);
        chk("req.cyc", dmem_cyc, 1'b0);
        ea = a;
        if (op == T_LDI || op == T_STI) begin
            bus_phase("ptr", op, 1'b1, a, wd, pline, wp);
            ea = m_word(pline, a);
        end
        bus_phase("acc", op, 1'b0, ea, wd, line, wa);
        if (m_load(op)) exp_rdata = (op == T_LDB) ? m_byte(line, ea) : m_word(line, ea);
        tick();
        dmem_resp = 1'b0;
        chk("done.pulse", done, 1'b1);
        chk("done.cyc", dmem_cyc, 1'b0);
        chk("done.stb", dmem_stb, 1'b0);
        chk("done.stall", stall, 1'b0);
        chk("done.rdata", rdata_out, exp_rdata);
        tick();
        chk("idle.done", done, 1'b0);
        chk("idle.cyc", dmem_cyc, 1'b0);
        chk("idle.rdata", rdata_out, exp_rdata);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]   ops [7];
        logic [127:0] ln, pl;
        ops = '{T_LDR, T_STR, T_LDB, T_STB, T_LDI, T_STI, T_TRAP};

        repeat (2) tick();
        chk("rst.cyc", dmem_cyc, 1'b0);
        chk("rst.stb", dmem_stb, 1'b0);
        chk("rst.write", dmem_write, 1'b0);
        chk("rst.be", dmem_byte_enable, 16'h0);
        chk("rst.addr", dmem_address, 16'h0);
        chk("rst.done", done, 1'b0);
        chk("rst.rdata", rdata_out, 16'h0);
        chk("rst.stall", stall, 1'b0);
        rst_n = 1'b1;
        tick();

        // Non-memory op and stray resp: no bus activity, no stall.
        req_valid = 1'b1; opcode = T_ADD; dmem_resp = 1'b1;
        #1;
        chk("nonmem.stall", stall, 1'b0);
        repeat (2) begin
            tick();
            chk("nonmem.cyc", dmem_cyc, 1'b0);
            chk("nonmem.done", done, 1'b0);
        end
        req_valid = 1'b0; opcode = T_LDR;
        #1;
        chk("novalid.stall", stall, 1'b0);
        tick();
        chk("novalid.cyc", dmem_cyc, 1'b0);
        dmem_resp = 1'b0;

        // Directed cases.
        ln = {4{$urandom()}};
        ln[63:48] = 16'hBEEF;
        run_txn(T_LDR, 16'h0016, 16'h0, '0, ln, 0, 2);
        chk("ldr.beef", rdata_out, 16'hBEEF);
        run_txn(T_STB, 16'h0025, 16'h12AB, '0, ln, 0, 1);
        chk("stb.keep", rdata_out, 16'hBEEF);
        ln = '0;
        ln[31:16] = 16'h8041;
        run_txn(T_LDB, 16'h0003, 16'h0, '0, ln, 0, 0);
        chk("ldb.hi", rdata_out, 16'hFF80);
        run_txn(T_LDB, 16'h0002, 16'h0, '0, ln, 0, 0);
        chk("ldb.lo", rdata_out, 16'h0041);
        pl = '0;
        pl[15:0] = 16'h3046;
        run_txn(T_STI, 16'h0010, 16'h5555, pl, ln, 1, 1);

        // Reset in the middle of an access, then a late resp.
        req_valid = 1'b1; opcode = T_LDR; addr = 16'h0040;
        tick();
        chk("rstmid.pre", dmem_cyc, 1'b1);
        rst_n = 1'b0; dmem_resp = 1'b1;
        #1;
        chk("rstmid.cyc", dmem_cyc, 1'b0);
        chk("rstmid.stb", dmem_stb, 1'b0);
        chk("rstmid.done", done, 1'b0);
        chk("rstmid.rdata", rdata_out, 16'h0);
        exp_rdata = '0;
        tick();
        req_valid = 1'b0; rst_n = 1'b1;
        repeat (2) begin
            tick();
            chk("rstmid.idle_cyc", dmem_cyc, 1'b0);
            chk("rstmid.idle_done", done, 1'b0);
        end
        dmem_resp = 1'b0;

        // Randomized back-to-back transactions.
        for (int n = 0; n < 40; n++) begin
            ln = {$urandom(), $urandom(), $urandom(), $urandom()};
            pl = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_txn(ops[$urandom_range(0, 6)], 16'($urandom()), 16'($urandom()), pl, ln,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
